// File: rtl/alu_instr_sequencer.sv
// alu_instr_sequencer: multi-cycle controller sequencing a 4-bit ALU over a 4x4 register file
//   clk, rst_n (async, active-low)
//   in_valid/in_ready/instr[8:0] : instruction handshake ({op, rd, rs, rt})
//   cfg_we/cfg_addr/cfg_data      : register-file load, honoured only in IDLE
//   out_valid/out_ready/out_data/out_rd : result handshake
//   busy, dbg_addr/dbg_data       : status and combinational register-file peek
//   Optional ALU_SEQ_STATS_EN adds retired_cnt[7:0] and zero_flag.

module Decode_And_Execute (
    input  logic [3:0] rs,
    input  logic [3:0] rt,
    input  logic [2:0] sel,
    output logic [3:0] rd
);
    always_comb
        rd = sel == 3'd0 ? rs - rt :
             sel == 3'd1 ? rs + rt :
             sel == 3'd2 ? rs | rt :
             sel == 3'd3 ? rs & rt :
             sel == 3'd4 ? {rt[3], rt[3:1]} :
             sel == 3'd5 ? {rs[2:0], rs[3]} :
             sel == 3'd6 ? {3'b000, rs < rt} :
                           {3'b111, rs == rt};
endmodule

module alu_instr_sequencer #(
    parameter int         EXEC_CYCLES  = 1,
    parameter logic [3:0] RF_RESET_VAL = 4'h0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [8:0] instr,
    input  logic       cfg_we,
    input  logic [1:0] cfg_addr,
    input  logic [3:0] cfg_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_data,
    output logic [1:0] out_rd,
    output logic       busy,
    input  logic [1:0] dbg_addr,
`ifdef ALU_SEQ_STATS_EN
    output logic [7:0] retired_cnt,
    output logic       zero_flag,
`endif
    output logic [3:0] dbg_data
);
    typedef enum logic [1:0] {IDLE, READ, EXEC, DONE} state_t;

    state_t     state_q, state_d;
    logic [2:0] op_q, op_d;
    logic [1:0] rd_q, rd_d, rs_q, rs_d, rt_q, rt_d;
    logic [3:0] a_q, a_d, b_q, b_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] rf_q [4];
    logic [3:0] rf_d [4];
    logic       out_valid_q, out_valid_d;
    logic [3:0] out_data_q, out_data_d;
    logic [1:0] out_rd_q, out_rd_d;
    logic [3:0] alu_res;
`ifdef ALU_SEQ_STATS_EN
    logic [7:0] retired_q, retired_d;
    logic       zero_q, zero_d;
`endif

    Decode_And_Execute u_alu (.rs(a_q), .rt(b_q), .sel(op_q), .rd(alu_res));

    assign in_ready  = state_q == IDLE && !cfg_we;
    assign busy      = state_q != IDLE;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_rd    = out_rd_q;
    assign dbg_data  = rf_q[dbg_addr];
`ifdef ALU_SEQ_STATS_EN
    assign retired_cnt = retired_q;
    assign zero_flag   = zero_q;
`endif

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        rd_d        = rd_q;
        rs_d        = rs_q;
        rt_d        = rt_q;
        a_d         = a_q;
        b_d         = b_q;
        cnt_d       = cnt_q;
        rf_d        = rf_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_rd_d    = out_rd_q;
`ifdef ALU_SEQ_STATS_EN
        retired_d   = retired_q;
        zero_d      = zero_q;
`endif
        case (state_q)
            IDLE: begin
                // A config write takes priority and blocks acceptance this cycle
                if (cfg_we) rf_d[cfg_addr] = cfg_data;
                else if (in_valid) begin
                    op_d    = instr[8:6];
                    rd_d    = instr[5:4];
                    rs_d    = instr[3:2];
                    rt_d    = instr[1:0];
                    state_d = READ;
                end
            end
            READ: begin
                a_d     = rf_q[rs_q];
                b_d     = rf_q[rt_q];
                cnt_d   = 4'(EXEC_CYCLES - 1);
                state_d = EXEC;
            end
            EXEC: begin
                if (cnt_q == 4'd0) begin
                    out_data_d  = alu_res;
                    out_rd_d    = rd_q;
                    out_valid_d = 1'b1;
                    rf_d[rd_q]  = alu_res;
`ifdef ALU_SEQ_STATS_EN
                    zero_d      = alu_res == 4'd0;
`endif
                    state_d     = DONE;
                end else cnt_d = cnt_q - 4'd1;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
`ifdef ALU_SEQ_STATS_EN
                    retired_d   = retired_q + 8'd1;
`endif
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= '0;
            rd_q        <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            cnt_q       <= '0;
            rf_q        <= '{default: RF_RESET_VAL};
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_rd_q    <= '0;
`ifdef ALU_SEQ_STATS_EN
            retired_q   <= '0;
            zero_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            rd_q        <= rd_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cnt_q       <= cnt_d;
            rf_q        <= rf_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_rd_q    <= out_rd_d;
`ifdef ALU_SEQ_STATS_EN
            retired_q   <= retired_d;
            zero_q      <= zero_d;
`endif
        end
    end
endmodule

// File: tb/tb_alu_instr_sequencer.sv
// tb_alu_instr_sequencer: scoreboard bench for alu_instr_sequencer
module tb_alu_instr_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0, rst4_n = 1'b0;
    logic       in_valid = 1'b0, in_valid4 = 1'b0;
    logic       in_ready, in_ready4;
    logic [8:0] instr = '0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_addr = '0;
    logic [3:0] cfg_data = '0;
    logic       out_valid, out_valid4;
    logic       out_ready = 1'b1;
    logic [3:0] out_data, out_data4;
    logic [1:0] out_rd, out_rd4;
    logic       busy, busy4;
    logic [1:0] dbg_addr = '0;
    logic [3:0] dbg_data, dbg_data4;
`ifdef ALU_SEQ_STATS_EN
    logic [7:0] retired_cnt, retired_cnt4;
    logic       zero_flag, zero_flag4;
`endif

    int total = 0;
    int bad = 0;
    int hs = 0;
    logic [5:0] exp_q [$];

    always #5 clk = ~clk;

    alu_instr_sequencer #(.EXEC_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd),
        .busy(busy), .dbg_addr(dbg_addr),
`ifdef ALU_SEQ_STATS_EN
        .retired_cnt(retired_cnt), .zero_flag(zero_flag),
`endif
        .dbg_data(dbg_data));

    alu_instr_sequencer #(.EXEC_CYCLES(4)) dut4 (
        .clk(clk), .rst_n(rst4_n), .in_valid(in_valid4), .in_ready(in_ready4), .instr(instr),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .out_valid(out_valid4), .out_ready(1'b1), .out_data(out_data4), .out_rd(out_rd4),
        .busy(busy4), .dbg_addr(dbg_addr),
`ifdef ALU_SEQ_STATS_EN
        .retired_cnt(retired_cnt4), .zero_flag(zero_flag4),
`endif
        .dbg_data(dbg_data4));

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: a handshake completes on the next rising edge whenever both are high here
    always @(negedge clk) begin
        #1;
        if (rst_n && out_valid && out_ready) begin
            hs++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected result: got rd=%0d data=%0h expected none", out_rd, out_data);
            end else chk("result {rd,data}", {2'b00, out_rd, out_data}, {2'b00, exp_q.pop_front()});
        end
    end

    task automatic cfg(input logic [1:0] a, input logic [3:0] d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic rd_rf(input string name, input logic [1:0] a, input logic [3:0] e);
        dbg_addr = a;
        #1;
        chk(name, {4'h0, dbg_data}, {4'h0, e});
    endtask

    task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                         input logic [1:0] rt, input logic [3:0] e);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        instr = {op, rd, rs, rt};
        #1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 100) chk("accept timeout", 8'd0, 8'd1);
        exp_q.push_back({rd, e});
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || out_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("idle timeout", 8'd0, 8'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and load
        repeat (2) @(negedge clk);
        chk("reset out_valid", {7'd0, out_valid}, 8'd0);
        chk("reset busy", {7'd0, busy}, 8'd0);
        rd_rf("reset rf2", 2'd2, 4'h0);
        rst_n = 1'b1;
        rst4_n = 1'b1;
        cfg(2'd0, 4'd5);
        cfg(2'd1, 4'd3);
        rd_rf("load r0", 2'd0, 4'd5);
        rd_rf("load r1", 2'd1, 4'd3);
        // Arithmetic chain; each reads the previous writeback
        issue(3'd0, 2'd2, 2'd0, 2'd1, 4'd2);
        issue(3'd1, 2'd3, 2'd0, 2'd1, 4'd8);
        issue(3'd1, 2'd0, 2'd0, 2'd3, 4'd13);
        wait_idle();
        rd_rf("writeback r2", 2'd2, 4'd2);
        rd_rf("writeback r0", 2'd0, 4'd13);
        // Logic, shift, compare
        cfg(2'd0, 4'd5);
        cfg(2'd1, 4'd3);
        cfg(2'd2, 4'b1010);
        cfg(2'd3, 4'b1001);
        issue(3'd4, 2'd2, 2'd0, 2'd2, 4'b1101);
        issue(3'd5, 2'd3, 2'd3, 2'd0, 4'b0011);
        issue(3'd2, 2'd2, 2'd0, 2'd1, 4'd7);
        issue(3'd3, 2'd3, 2'd0, 2'd1, 4'd1);
        issue(3'd6, 2'd2, 2'd1, 2'd0, 4'b0001);
        issue(3'd7, 2'd2, 2'd0, 2'd0, 4'b1111);
        issue(3'd7, 2'd3, 2'd0, 2'd1, 4'b1110);
        wait_idle();
        rd_rf("writeback r3", 2'd3, 4'b1110);
        // Back-pressure: result held while out_ready is low
        out_ready = 1'b0;
        issue(3'd1, 2'd2, 2'd0, 2'd1, 4'd8);
        for (int i = 0; i < 10 && !out_valid; i++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("stall out_valid", {7'd0, out_valid}, 8'd1);
            chk("stall out_data", {4'h0, out_data}, 8'd8);
            chk("stall out_rd", {6'd0, out_rd}, 8'd2);
            chk("stall in_ready", {7'd0, in_ready}, 8'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        wait_idle();
        // cfg write and instruction in the same IDLE cycle: cfg first, accept next
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = 2'd1; cfg_data = 4'd6;
        in_valid = 1'b1; instr = {3'd1, 2'd3, 2'd0, 2'd1};
        #1;
        chk("cfg blocks in_ready", {7'd0, in_ready}, 8'd0);
        @(negedge clk);
        cfg_we = 1'b0;
        #1;
        chk("in_ready after cfg", {7'd0, in_ready}, 8'd1);
        exp_q.push_back({2'd3, 4'd11});
        @(negedge clk);
        in_valid = 1'b0;
        chk("accepted busy", {7'd0, busy}, 8'd1);
        wait_idle();
        rd_rf("cfg r1", 2'd1, 4'd6);
        // cfg during EXEC is ignored
        issue(3'd3, 2'd2, 2'd0, 2'd1, 4'd4);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 4'hf;
        @(negedge clk);
        cfg_we = 1'b0;
        wait_idle();
        rd_rf("cfg in EXEC ignored", 2'd0, 4'd5);
`ifdef ALU_SEQ_STATS_EN
        chk("retired_cnt", retired_cnt, 8'(hs));
`endif
        // EXEC_CYCLES=4 instance: latency then reset mid-EXEC
        cfg(2'd0, 4'd5);
        cfg(2'd1, 4'd3);
        @(negedge clk);
        in_valid4 = 1'b1; instr = {3'd1, 2'd2, 2'd0, 2'd1};
        @(negedge clk);
        in_valid4 = 1'b0;
        repeat (4) @(negedge clk);
        chk("lat4 before", {7'd0, out_valid4}, 8'd0);
        @(negedge clk);
        chk("lat4 out_valid", {7'd0, out_valid4}, 8'd1);
        chk("lat4 out_data", {4'h0, out_data4}, 8'd8);
        chk("lat4 out_rd", {6'd0, out_rd4}, 8'd2);
        @(negedge clk);
        chk("lat4 released", {7'd0, out_valid4}, 8'd0);
        @(negedge clk);
        in_valid4 = 1'b1; instr = {3'd0, 2'd3, 2'd0, 2'd1};
        @(negedge clk);
        in_valid4 = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid-EXEC busy", {7'd0, busy4}, 8'd1);
        rst4_n = 1'b0;
        #1;
        chk("reset busy4", {7'd0, busy4}, 8'd0);
        @(negedge clk);
        rst4_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            dbg_addr = 2'(a);
            #1;
            chk("reset rf4", {4'h0, dbg_data4}, 8'd0);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("no out_valid4 after reset", {7'd0, out_valid4}, 8'd0);
        end
`ifdef ALU_SEQ_STATS_EN
        chk("retired_cnt4 reset", retired_cnt4, 8'd0);
`endif
        chk("scoreboard drained", 8'(exp_q.size()), 8'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
